div_seq_param: RTL and testbench
================================

Name: div_seq_param

Overview:
- Parametrised multi-cycle integer divider for the multicycle processor datapath.
- Successor to the fixed 32-bit signed sequential divider. Adds:
  - configurable width;
  - a per-operation signed/unsigned mode;
  - one-cycle early completion on divide-by-zero and signed overflow;
  - a synchronous cancel.
- Computes one quotient bit per clock (radix-2 restoring) and is driven by the control unit via a start/busy/done handshake.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
start  in  1  request; sampled only in IDLE
kill  in  1  synchronous cancel of an operation in flight
sgn  in  1  1 = signed (two's complement) operands, 0 = unsigned; sampled with start
a  in  WIDTH  dividend; sampled with start
b  in  WIDTH  divisor; sampled with start
busy  out  1  operation in progress
done  out  1  one-cycle pulse: val/rem/dbz/ovf valid
dbz  out  1  last operation divided by zero
ovf  out  1  last operation was signed MIN / -1
val  out  WIDTH  quotient
rem  out  WIDTH  remainder

Behaviour:
Reset (rst=0, asynchronous):
- State goes to IDLE.
- busy=0, done=0, dbz=0, ovf=0, val=0, rem=0.
- Internal counter and registers are cleared.

States: IDLE, RUN, FIX, DONE.

IDLE:
- If start=1 at a clock edge, latch a, b, sgn and clear dbz/ovf.
- If b==0: go to DONE with val = all ones, rem = a, dbz=1.
- Else if sgn=1 and a == 1<<(WIDTH-1) and b == all ones: go to DONE with val=a, rem=0, ovf=1.
- Else:
  - Take magnitudes |a| and |b| (only when sgn=1 and the MSB is set).
  - Record neg_q = a[MSB]^b[MSB] and neg_r = a[MSB], both gated by sgn.
  - Load acc=0, set count=0, go to RUN, set busy=1.

RUN:
- Per cycle, on a (WIDTH+1)-bit accumulator:
  - shift {acc, quo} left by 1;
  - if acc >= |b|, subtract |b| and set quo[0]=1.
- count increments each cycle; after WIDTH cycles go to FIX.

FIX:
- val = neg_q ? -quo : quo.
- rem = neg_r ? -acc : acc.
- Go to DONE.

DONE:
- done=1 for exactly one cycle, busy=0, then return to IDLE.

Latency:
- Normal operation: start edge E0, busy=1 from E0 until E0+WIDTH+1, done=1 during the cycle after edge E0+WIDTH+2 (WIDTH+2 cycles total).
- dbz or ovf: done=1 after edge E0+1, and busy never asserts.

Output holding:
- val, rem, dbz and ovf hold their values until the next accepted start.
- They are not valid while busy=1.

Sign rule:
- Truncating division: the quotient rounds toward zero and the remainder takes the dividend's sign.
- a == val*b + rem holds mod 2^WIDTH for all non-dbz cases.

start handling:
- start while busy or in DONE is ignored; it is not queued.
- start and done in the same cycle: start is not accepted; the control unit must re-assert it.

kill:
- kill=1 in RUN or FIX sends the state to IDLE on the next edge with busy=0, done not pulsed, and outputs unchanged.
- kill in IDLE has no effect.
- kill has priority over start in the same cycle.

Unknown inputs:
- X on a/b/sgn is ignored unless start is accepted.

Test Plan:
- WIDTH=32, sgn=1, a=100, b=7 -> done exactly 34 cycles after the start edge; val=14, rem=2, dbz=0, ovf=0; busy high for 33 cycles.
- WIDTH=32, sgn=1, a=-100, b=7 -> val=-14 (0xFFFFFFF2), rem=-2. With a=100, b=-7 -> val=-14, rem=2. With sgn=0, a=0xFFFFFFFF, b=2 -> val=0x7FFFFFFF, rem=1.
- b=0, a=0x1234 -> done 1 cycle after start, dbz=1, val=0xFFFFFFFF, rem=0x1234, busy never 1. Next valid start clears dbz.
- sgn=1, a=0x80000000, b=0xFFFFFFFF -> done after 1 cycle, ovf=1, val=0x80000000, rem=0. Same operands with sgn=0 -> normal 34-cycle run, val=0, rem=0x80000000.
- Start a division, assert kill at cycle 10 -> busy drops next edge, no done pulse, val/rem keep previous results. start asserted mid-RUN -> ignored, original result returned.
- WIDTH=8 instance, sgn=1, a=-128, b=3 -> done after 10 cycles, val=0xD6 (-42), rem=0xFE (-2). Assert rst=0 mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/div_seq_param.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_param
// Purpose  : Parametrised radix-2 restoring divider, signed/unsigned, one
//            quotient bit per clock, with early exit and cancel.
// Revision : 1.0
// ============================================================================
module div_seq_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             ovf,
    output logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] rem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   div_q;
    logic               qneg_q;
    logic               rneg_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic               ovf_q;
    logic [WIDTH-1:0]   val_q;
    logic [WIDTH-1:0]   rem_q;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               a_is_min;
    logic [WIDTH:0]     shift;
    logic               ge;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   val_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        mag_a    = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b    = (sgn && b[WIDTH-1]) ? -b : b;
        a_is_min = (a == {1'b1, {(WIDTH-1){1'b0}}});
        // The partial remainder always stays below the divisor, so only the
        // shifted value needs the extra bit.
        shift    = {acc_q, quo_q[WIDTH-1]};
        ge       = (shift >= {1'b0, div_q});
        acc_d    = ge ? WIDTH'(shift - {1'b0, div_q}) : shift[WIDTH-1:0];
        quo_d    = {quo_q[WIDTH-2:0], ge};
        val_fix  = qneg_q ? -quo_q : quo_q;
        rem_fix  = rneg_q ? -acc_q : acc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            val_q   <= '0;
            rem_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done_q) begin
                        dbz_q <= 1'b0;
                        ovf_q <= 1'b0;
                        if (b == '0) begin
                            val_q   <= '1;
                            rem_q   <= a;
                            dbz_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else if (sgn && a_is_min && (&b)) begin
                            val_q   <= a;
                            rem_q   <= '0;
                            ovf_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            div_q   <= mag_b;
                            quo_q   <= mag_a;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            qneg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rneg_q  <= sgn & a[WIDTH-1];
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (kill) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    busy_q  <= 1'b0;
                    if (kill) begin
                        state_q <= S_IDLE;
                    end else begin
                        val_q   <= val_fix;
                        rem_q   <= rem_fix;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dbz  = dbz_q;
    assign ovf  = ovf_q;
    assign val  = val_q;
    assign rem  = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_param.sv
`default_nettype none
// Bench for div_seq_param: 32-bit and 8-bit instances checked against an
// arithmetic reference model with directed and random operations.
module tb_div_seq_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic        sgn;
    logic        sel;
    logic [31:0] a_in;
    logic [31:0] b_in;

    logic        busy32, done32, dbz32, ovf32;
    logic [31:0] val32, rem32;
    logic        busy8, done8, dbz8, ovf8;
    logic [7:0]  val8, rem8;

    logic        busy_m, done_m, dbz_m, ovf_m;
    logic [31:0] val_m, rem_m;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    div_seq_param #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .start (start & ~sel),
        .kill  (kill & ~sel),
        .sgn   (sgn),
        .a     (a_in),
        .b     (b_in),
        .busy  (busy32),
        .done  (done32),
        .dbz   (dbz32),
        .ovf   (ovf32),
        .val   (val32),
        .rem   (rem32)
    );

    div_seq_param #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start & sel),
        .kill  (kill & sel),
        .sgn   (sgn),
        .a     (a_in[7:0]),
        .b     (b_in[7:0]),
        .busy  (busy8),
        .done  (done8),
        .dbz   (dbz8),
        .ovf   (ovf8),
        .val   (val8),
        .rem   (rem8)
    );

    assign busy_m = sel ? busy8 : busy32;
    assign done_m = sel ? done8 : done32;
    assign dbz_m  = sel ? dbz8  : dbz32;
    assign ovf_m  = sel ? ovf8  : ovf32;
    assign val_m  = sel ? {24'd0, val8} : val32;
    assign rem_m  = sel ? {24'd0, rem8} : rem32;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Truncating division computed with 64-bit signed arithmetic.
    function automatic void model(input int w, input logic s, input logic [31:0] av,
                                  input logic [31:0] bv, output logic [31:0] q,
                                  output logic [31:0] r, output logic dz, output logic ov);
        logic [31:0] mask;
        logic [31:0] minv;
        longint      sa, sb;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        minv = 32'd1 << (w - 1);
        av   = av & mask;
        bv   = bv & mask;
        dz   = 1'b0;
        ov   = 1'b0;
        if (bv == 32'd0) begin
            q  = mask;
            r  = av;
            dz = 1'b1;
        end else if (s && av == minv && bv == mask) begin
            q  = av;
            r  = 32'd0;
            ov = 1'b1;
        end else begin
            sa = longint'(av);
            sb = longint'(bv);
            if (s && (av & minv) != 0) sa = sa - (longint'(1) << w);
            if (s && (bv & minv) != 0) sb = sb - (longint'(1) << w);
            q = 32'(sa / sb) & mask;
            r = 32'(sa % sb) & mask;
        end
    endfunction

    task automatic start_op(input logic s, input logic [31:0] av, input logic [31:0] bv);
        sgn   = s;
        a_in  = av;
        b_in  = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sgn   = 1'bx;
        a_in  = 'x;
        b_in  = 'x;
    endtask

    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = busy_m ? 1 : 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done_m) break;
            if (busy_m) bc++;
        end
        if (n >= 200) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_op(input string tag, input logic s, input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] q, r;
        logic        dz, ov;
        int          n, bc, w;
        w = sel ? 8 : 32;
        model(w, s, av, bv, q, r, dz, ov);
        start_op(s, av, bv);
        wait_done(n, bc);
        chk({tag, "_lat"},  64'(n),  (dz | ov) ? 64'd1 : 64'(w + 2));
        chk({tag, "_busy"}, 64'(bc), (dz | ov) ? 64'd0 : 64'(w + 1));
        chk({tag, "_val"},  64'(val_m), 64'(q));
        chk({tag, "_rem"},  64'(rem_m), 64'(r));
        chk({tag, "_flags"}, {62'd0, dbz_m, ovf_m}, {62'd0, dz, ov});
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'(done_m), 64'd0);
    endtask

    initial begin
        logic [31:0] q, r, av, bv;
        logic        dz, ov, seen, s;
        int          n, bc, k;

        rst   = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        sgn   = 1'b0;
        sel   = 1'b0;
        a_in  = 32'd0;
        b_in  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst32_flags", {60'd0, busy32, done32, dbz32, ovf32}, 64'd0);
        chk("rst32_valrem", {val32, rem32}, 64'd0);
        chk("rst8_all", {44'd0, busy8, done8, dbz8, ovf8, val8, rem8}, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        do_op("s100_7",    1'b1, 32'd100, 32'd7);
        do_op("sm100_7",   1'b1, 32'hFFFF_FF9C, 32'd7);
        do_op("s100_m7",   1'b1, 32'd100, 32'hFFFF_FFF9);
        do_op("u_max_2",   1'b0, 32'hFFFF_FFFF, 32'd2);
        do_op("dbz",       1'b1, 32'h1234, 32'd0);
        do_op("after_dbz", 1'b1, 32'd100, 32'd7);
        do_op("ovf",       1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("ovf_unsgn", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

        // Cancel mid-run: previous result (14, 2) must survive.
        do_op("pre_kill", 1'b1, 32'd100, 32'd7);
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill_busy", 64'(busy_m), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_m) seen = 1'b1;
        end
        chk("kill_nodone", 64'(seen), 64'd0);
        chk("kill_val", 64'(val_m), 64'd14);
        chk("kill_rem", 64'(rem_m), 64'd2);

        // A start pulse during RUN is ignored.
        start_op(1'b1, 32'hFFFF_FFCE, 32'd6);
        repeat (5) @(posedge clk);
        #1;
        sgn = 1'b0; a_in = 32'd1; b_in = 32'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, bc);
        chk("midstart_lat", 64'(n), 64'd28);
        chk("midstart_val", 64'(val_m), 64'hFFFF_FFF8);
        chk("midstart_rem", 64'(rem_m), 64'hFFFF_FFFE);
        @(posedge clk);
        #1;

        // start held through the done pulse is not accepted that cycle.
        sgn = 1'b0; a_in = 32'd77; b_in = 32'd5; start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (done_m) begin
                seen = 1'b1;
                break;
            end
        end
        chk("hold_done_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        chk("start_at_done_ignored", 64'(busy_m), 64'd0);
        @(posedge clk);
        #1;
        chk("restart_accepted", 64'(busy_m), 64'd1);
        start = 1'b0;
        wait_done(n, bc);
        chk("restart_val", 64'(val_m), 64'd15);
        chk("restart_rem", 64'(rem_m), 64'd2);
        @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 9);
            s  = 1'($urandom_range(0, 1));
            av = $urandom;
            bv = $urandom;
            if (k == 0) bv = 32'd0;
            if (k == 1) begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; s = 1'b1; end
            if (k == 2) bv = $urandom_range(1, 15);
            if (k == 3) bv = -$urandom_range(1, 15);
            do_op("rand32", s, av, bv);
        end

        sel = 1'b1;
        do_op("w8_m128_3", 1'b1, 32'h80, 32'd3);
        for (int i = 0; i < 30; i++) begin
            k  = $urandom_range(0, 7);
            s  = 1'($urandom_range(0, 1));
            av = $urandom & 32'hFF;
            bv = $urandom & 32'hFF;
            if (k == 0) bv = 32'd0;
            if (k == 1) begin av = 32'h80; bv = 32'hFF; s = 1'b1; end
            do_op("rand8", s, av, bv);
        end

        // Asynchronous reset between clock edges during RUN.
        do_op("w8_pre_rst", 1'b1, 32'h80, 32'd3);
        start_op(1'b0, 32'd200, 32'd7);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst8", {44'd0, busy8, done8, dbz8, ovf8, val8, rem8}, 64'd0);
        chk("async_rst32", {val32[31:0], rem32[31:0]}, 64'd0);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_op("w8_post_rst", 1'b0, 32'd200, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
